divider: RTL and testbench

- Sequential restoring divider: quotient = dividend / divisor, remainder = dividend % divisor, both unsigned.
- It is the inverse-direction companion to the team's shift-and-add multiplier and uses the same control handshake: i_start in, o_finished pulse out.
- Produces one quotient bit per clock.
- Sits alongside the multiplier in the arithmetic datapath.

---
 rtl/divider_pkg.sv | 23 ++
 rtl/divider_step.sv | 30 +++
 rtl/divider.sv | 116 +++++++++++
 tb/tb_divider.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared arithmetic-datapath definitions: control FSM states and a clog2 helper.
package divider_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Ceiling log2 for sizing counters; valid for value >= 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/divider_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial subtract.
module divider_step
    import divider_pkg::*;
#(
    parameter int unsigned BITS = 8
) (
    input  logic [BITS-1:0] i_partial_rem,
    input  logic            i_next_bit,
    input  logic [BITS-1:0] i_divisor,
    output logic [BITS-1:0] o_partial_rem,
    output logic            o_quotient_bit
);

    logic [BITS:0] shifted;
    logic [BITS:0] diff;

    // Keep the difference when it is non-negative, otherwise restore the shifted value.
    always_comb begin
        shifted = {i_partial_rem, i_next_bit};
        diff    = shifted - {1'b0, i_divisor};
        if (!diff[BITS]) begin
            o_partial_rem  = diff[BITS-1:0];
            o_quotient_bit = 1'b1;
        end else begin
            o_partial_rem  = shifted[BITS-1:0];
            o_quotient_bit = 1'b0;
        end
    end

endmodule

// File: rtl/divider.sv
// Sequential restoring divider: one quotient bit per clock, i_start / o_finished handshake.
module divider
    import divider_pkg::*;
#(
    parameter int unsigned BITS = 8
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic            i_start,
    output logic            o_busy,
    output logic            o_finished,
    input  logic [BITS-1:0] i_dividend,
    input  logic [BITS-1:0] i_divisor,
    output logic [BITS-1:0] o_quotient,
    output logic [BITS-1:0] o_remainder,
    output logic            o_div_by_zero
);

    localparam int unsigned        CNT_W = clog2(BITS);
    localparam logic [CNT_W-1:0]   LAST  = CNT_W'(BITS - 1);

    state_e          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BITS-1:0] work_q, work_d;
    // The partial remainder stays below the divisor between steps, so its
    // top (BITS) bit is always zero and only BITS bits are stored.
    logic [BITS-1:0] rem_q, rem_d;
    logic [BITS-1:0] divisor_q, divisor_d;
    logic            dbz_q, dbz_d;
    logic [BITS-1:0] quot_q, quot_d;
    logic [BITS-1:0] remo_q, remo_d;
    logic            dbz_out_q, dbz_out_d;

    logic [BITS-1:0] step_rem;
    logic            step_qbit;

    divider_step #(.BITS(BITS)) u_step (
        .i_partial_rem  (rem_q),
        .i_next_bit     (work_q[BITS-1]),
        .i_divisor      (divisor_q),
        .o_partial_rem  (step_rem),
        .o_quotient_bit (step_qbit)
    );

    // Next-state, operand capture, iteration and result capture.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        rem_d     = rem_q;
        divisor_d = divisor_q;
        dbz_d     = dbz_q;
        quot_d    = quot_q;
        remo_d    = remo_q;
        dbz_out_d = dbz_out_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    state_d   = ST_RUN;
                    divisor_d = i_divisor;
                    work_d    = i_dividend;
                    rem_d     = '0;
                    cnt_d     = '0;
                    dbz_d     = (i_divisor == '0);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                work_d = {work_q[BITS-2:0], step_qbit};
                rem_d  = step_rem;
                if (cnt_q == LAST) begin
                    state_d   = ST_DONE;
                    quot_d    = {work_q[BITS-2:0], step_qbit};
                    remo_d    = step_rem;
                    dbz_out_d = dbz_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            work_q    <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
            dbz_q     <= 1'b0;
            quot_q    <= '0;
            remo_q    <= '0;
            dbz_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            rem_q     <= rem_d;
            divisor_q <= divisor_d;
            dbz_q     <= dbz_d;
            quot_q    <= quot_d;
            remo_q    <= remo_d;
            dbz_out_q <= dbz_out_d;
        end
    end

    assign o_busy        = (state_q == ST_RUN);
    assign o_finished    = (state_q == ST_DONE);
    assign o_quotient    = quot_q;
    assign o_remainder   = remo_q;
    assign o_div_by_zero = dbz_out_q;

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed scenarios plus a randomized sweep.
module tb_divider;

    localparam int unsigned BITS = 8;

    logic            i_clock = 1'b0;
    logic            i_reset = 1'b1;
    logic            i_start = 1'b0;
    logic            o_busy;
    logic            o_finished;
    logic [BITS-1:0] i_dividend = '0;
    logic [BITS-1:0] i_divisor  = '0;
    logic [BITS-1:0] o_quotient;
    logic [BITS-1:0] o_remainder;
    logic            o_div_by_zero;

    int unsigned n_cmp   = 0;
    int unsigned n_fail  = 0;
    int unsigned fin_cnt = 0;

    divider #(.BITS(BITS)) dut (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_start       (i_start),
        .o_busy        (o_busy),
        .o_finished    (o_finished),
        .i_dividend    (i_dividend),
        .i_divisor     (i_divisor),
        .o_quotient    (o_quotient),
        .o_remainder   (o_remainder),
        .o_div_by_zero (o_div_by_zero)
    );

    always #5 i_clock = ~i_clock;

    always @(negedge i_clock) if (o_finished === 1'b1) fin_cnt++;

    // Reference model: plain unsigned arithmetic, divisor 0 gives all ones / dividend.
    function automatic logic [BITS-1:0] ref_q(input logic [BITS-1:0] a, input logic [BITS-1:0] b);
        return (b == 0) ? {BITS{1'b1}} : a / b;
    endfunction

    function automatic logic [BITS-1:0] ref_r(input logic [BITS-1:0] a, input logic [BITS-1:0] b);
        return (b == 0) ? a : a % b;
    endfunction

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic launch(input logic [BITS-1:0] a, input logic [BITS-1:0] b);
        i_dividend = a;
        i_divisor  = b;
        i_start    = 1'b1;
        tick();
        i_start    = 1'b0;
    endtask

    // Bounded wait for o_finished; lat counts edges after the current sample point.
    task automatic wait_finish(output int unsigned lat, output int unsigned busy_cycles);
        lat = 0;
        busy_cycles = 0;
        while (o_finished !== 1'b1 && lat < 40) begin
            if (o_busy === 1'b1) busy_cycles++;
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        i_start = 1'b0;
        tick();
        tick();
        i_reset = 1'b0;
        n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        n_cmp++; if (o_finished !== 1'b0) begin n_fail++; $display("FAIL reset_finished: got %b want 0", o_finished); end
        n_cmp++; if (o_quotient !== 8'd0) begin n_fail++; $display("FAIL reset_q: got %0d want 0", o_quotient); end
        n_cmp++; if (o_remainder !== 8'd0) begin n_fail++; $display("FAIL reset_r: got %0d want 0", o_remainder); end
        n_cmp++; if (o_div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz: got %b want 0", o_div_by_zero); end
        tick();
        n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", o_busy); end
    endtask

    task automatic test_basic();
        int unsigned lat, bc;
        launch(8'd100, 8'd7);
        wait_finish(lat, bc);
        n_cmp++; if (lat != 8) begin n_fail++; $display("FAIL basic_latency: got %0d want 8", lat); end
        n_cmp++; if (bc != 8) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d want 8", bc); end
        n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_done: got %b want 0", o_busy); end
        n_cmp++; if (o_quotient !== 8'd14) begin n_fail++; $display("FAIL basic_q: got %0d want 14", o_quotient); end
        n_cmp++; if (o_remainder !== 8'd2) begin n_fail++; $display("FAIL basic_r: got %0d want 2", o_remainder); end
        n_cmp++; if (o_div_by_zero !== 1'b0) begin n_fail++; $display("FAIL basic_dbz: got %b want 0", o_div_by_zero); end
        tick();
        n_cmp++; if (o_finished !== 1'b0) begin n_fail++; $display("FAIL basic_pulse_width: got %b want 0", o_finished); end
        n_cmp++; if (o_quotient !== 8'd14) begin n_fail++; $display("FAIL basic_q_hold: got %0d want 14", o_quotient); end
    endtask

    task automatic test_back_to_back();
        int unsigned lat, bc, held_bad;
        launch(8'd255, 8'd1);
        wait_finish(lat, bc);
        n_cmp++; if (o_quotient !== 8'd255) begin n_fail++; $display("FAIL b2b_first_q: got %0d want 255", o_quotient); end
        n_cmp++; if (o_remainder !== 8'd0) begin n_fail++; $display("FAIL b2b_first_r: got %0d want 0", o_remainder); end
        launch(8'd5, 8'd9);
        n_cmp++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept_from_done: got %b want 1", o_busy); end
        lat = 0;
        held_bad = 0;
        while (o_finished !== 1'b1 && lat < 40) begin
            if (o_quotient !== 8'd255 || o_remainder !== 8'd0) held_bad++;
            tick();
            lat++;
        end
        n_cmp++; if (held_bad != 0) begin n_fail++; $display("FAIL b2b_held: %0d cycles changed, want 0", held_bad); end
        n_cmp++; if (lat != 8) begin n_fail++; $display("FAIL b2b_latency: got %0d want 8", lat); end
        n_cmp++; if (o_quotient !== 8'd0) begin n_fail++; $display("FAIL b2b_second_q: got %0d want 0", o_quotient); end
        n_cmp++; if (o_remainder !== 8'd5) begin n_fail++; $display("FAIL b2b_second_r: got %0d want 5", o_remainder); end
        tick();
    endtask

    task automatic test_div_zero();
        int unsigned lat, bc;
        launch(8'd42, 8'd0);
        wait_finish(lat, bc);
        n_cmp++; if (lat != 8) begin n_fail++; $display("FAIL dz_latency: got %0d want 8", lat); end
        n_cmp++; if (o_quotient !== 8'd255) begin n_fail++; $display("FAIL dz_q: got %0d want 255", o_quotient); end
        n_cmp++; if (o_remainder !== 8'd42) begin n_fail++; $display("FAIL dz_r: got %0d want 42", o_remainder); end
        n_cmp++; if (o_div_by_zero !== 1'b1) begin n_fail++; $display("FAIL dz_flag: got %b want 1", o_div_by_zero); end
        tick();
    endtask

    task automatic test_ignore_start();
        int unsigned lat, bc, f0, extra_busy;
        f0 = fin_cnt;
        launch(8'd200, 8'd3);
        tick();
        tick();
        i_start    = 1'b1;
        i_dividend = 8'd9;
        i_divisor  = 8'd9;
        tick();
        i_start    = 1'b0;
        i_dividend = BITS'($urandom);
        i_divisor  = BITS'($urandom);
        wait_finish(lat, bc);
        n_cmp++; if (lat != 5) begin n_fail++; $display("FAIL ign_latency: got %0d want 5", lat); end
        n_cmp++; if (o_quotient !== 8'd66) begin n_fail++; $display("FAIL ign_q: got %0d want 66", o_quotient); end
        n_cmp++; if (o_remainder !== 8'd2) begin n_fail++; $display("FAIL ign_r: got %0d want 2", o_remainder); end
        extra_busy = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (o_busy !== 1'b0) extra_busy++;
        end
        n_cmp++; if (extra_busy != 0) begin n_fail++; $display("FAIL ign_no_restart: busy %0d cycles want 0", extra_busy); end
        n_cmp++; if (fin_cnt - f0 != 1) begin n_fail++; $display("FAIL ign_finish_count: got %0d want 1", fin_cnt - f0); end
    endtask

    task automatic test_reset_mid_run();
        int unsigned lat, bc, f0, extra_busy;
        f0 = fin_cnt;
        launch(8'd77, 8'd4);
        tick();
        tick();
        tick();
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b want 0", o_busy); end
        n_cmp++; if (o_quotient !== 8'd0) begin n_fail++; $display("FAIL rmid_q: got %0d want 0", o_quotient); end
        n_cmp++; if (o_remainder !== 8'd0) begin n_fail++; $display("FAIL rmid_r: got %0d want 0", o_remainder); end
        n_cmp++; if (o_div_by_zero !== 1'b0) begin n_fail++; $display("FAIL rmid_dbz: got %b want 0", o_div_by_zero); end
        extra_busy = 0;
        for (int i = 0; i < 12; i++) begin
            if (o_busy !== 1'b0) extra_busy++;
            tick();
        end
        n_cmp++; if (extra_busy != 0) begin n_fail++; $display("FAIL rmid_stays_idle: busy %0d cycles want 0", extra_busy); end
        n_cmp++; if (fin_cnt != f0) begin n_fail++; $display("FAIL rmid_no_finish: got %0d pulses want 0", fin_cnt - f0); end
        // Reset asserted together with start must win.
        i_reset    = 1'b1;
        i_start    = 1'b1;
        i_dividend = 8'd10;
        i_divisor  = 8'd3;
        tick();
        i_reset = 1'b0;
        i_start = 1'b0;
        n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_beats_start: busy %b want 0", o_busy); end
        tick();
        launch(8'd77, 8'd4);
        wait_finish(lat, bc);
        n_cmp++; if (lat != 8) begin n_fail++; $display("FAIL rmid_retry_latency: got %0d want 8", lat); end
        n_cmp++; if (o_quotient !== 8'd19) begin n_fail++; $display("FAIL rmid_retry_q: got %0d want 19", o_quotient); end
        n_cmp++; if (o_remainder !== 8'd1) begin n_fail++; $display("FAIL rmid_retry_r: got %0d want 1", o_remainder); end
        tick();
    endtask

    task automatic test_random();
        int unsigned lat, bc, f0, starts, gap;
        logic [BITS-1:0] a, b;
        f0 = fin_cnt;
        starts = 0;
        for (int n = 0; n < 500; n++) begin
            a = BITS'($urandom);
            b = ($urandom_range(0, 15) == 0) ? '0 : BITS'($urandom);
            launch(a, b);
            starts++;
            wait_finish(lat, bc);
            n_cmp++; if (lat != 8) begin n_fail++; $display("FAIL rnd_latency %0d/%0d: got %0d want 8", a, b, lat); end
            n_cmp++; if (o_quotient !== ref_q(a, b)) begin n_fail++; $display("FAIL rnd_q %0d/%0d: got %0d want %0d", a, b, o_quotient, ref_q(a, b)); end
            n_cmp++; if (o_remainder !== ref_r(a, b)) begin n_fail++; $display("FAIL rnd_r %0d/%0d: got %0d want %0d", a, b, o_remainder, ref_r(a, b)); end
            n_cmp++; if (o_div_by_zero !== (b == 0)) begin n_fail++; $display("FAIL rnd_dbz %0d/%0d: got %b want %b", a, b, o_div_by_zero, (b == 0)); end
            if ($urandom_range(0, 1) == 1) begin
                gap = $urandom_range(1, 3);
                for (int g = 0; g < int'(gap); g++) tick();
            end
        end
        tick();
        tick();
        n_cmp++; if (fin_cnt - f0 != starts) begin n_fail++; $display("FAIL rnd_finish_count: got %0d want %0d", fin_cnt - f0, starts); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_div_zero();
        test_ignore_start();
        test_reset_mid_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
